// File: rtl/wb_timer.sv
// Wishbone-classic timer slave: prescaler, 32-bit up-counter with compare
// match, one-shot or auto-reload, level interrupt for the picorv32 irq vector.
module wb_timer #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  logic                      en;
  logic                      auto_reload;
  logic                      irq_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] psc;
  logic [31:0]               compare;
  logic [31:0]               count;
  logic                      pend;

  // Handshake: a request is cyc & stb sampled while ack is low; ack is raised
  // for one cycle on that edge and is then forced low for one cycle, so a
  // master holding stb gets at most one access every two cycles.
  logic       access;
  logic       wr;
  logic [2:0] idx;
  assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = access & wb_we_i;
  assign idx    = wb_adr_i[4:2];

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  logic wr_ctrl, wr_psc, wr_cmp, wr_cnt, wr_sts;
  assign wr_ctrl = wr && (idx == 3'd0) && wb_sel_i[0];
  assign wr_psc  = wr && (idx == 3'd1);
  assign wr_cmp  = wr && (idx == 3'd2);
  assign wr_cnt  = wr && (idx == 3'd3);
  assign wr_sts  = wr && (idx == 3'd4) && wb_sel_i[0];

  logic [31:0] lane_mask;
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[b*8 +: 8] = {8{wb_sel_i[b]}};
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [PRESCALE_WIDTH-1:0] prescale_wr;
  always_comb begin
    prescale_wr = prescale;
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if (lane_mask[i]) prescale_wr[i] = wb_dat_i[i];
    end
  end

  logic tick;
  logic match;
  logic hw_hit;
  assign tick   = en && (psc == prescale);
  assign match  = (count == compare);
  // A software COUNT write on a tick edge suppresses the compare entirely.
  assign hw_hit = tick && match && !wr_cnt;

  logic [31:0] rd_data;
  always_comb begin
    case (idx)
      3'd0:    rd_data = {29'd0, irq_en, auto_reload, en};
      3'd1:    rd_data = 32'(prescale);
      3'd2:    rd_data = compare;
      3'd3:    rd_data = count;
      3'd4:    rd_data = {31'd0, pend};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 32'd0;
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      psc         <= '0;
      compare     <= 32'hFFFF_FFFF;
      count       <= 32'd0;
      pend        <= 1'b0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= access ? rd_data : 32'd0;

      if (wr_psc || (wr_ctrl && wb_dat_i[0] && !en) || !en || tick) begin
        psc <= '0;
      end else begin
        psc <= psc + 1'b1;
      end

      if (wr_ctrl) begin
        en          <= wb_dat_i[0];
        auto_reload <= wb_dat_i[1];
        irq_en      <= wb_dat_i[2];
      end
      if (hw_hit && !auto_reload) en <= 1'b0;

      if (wr_psc) prescale <= prescale_wr;
      if (wr_cmp) compare  <= merge(compare, wb_dat_i, lane_mask);

      if (wr_cnt) begin
        count <= merge(count, wb_dat_i, lane_mask);
      end else if (tick) begin
        if (match) begin
          if (auto_reload) count <= 32'd0;
        end else begin
          count <= count + 32'd1;
        end
      end

      // Hardware set is written last so it wins over a same-cycle clear.
      if (wr_sts && wb_dat_i[0]) pend <= 1'b0;
      if (hw_hit)                pend <= 1'b1;
    end
  end

  assign irq_o = pend & irq_en;

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer: register access timing, timer
// modes, collision cases, byte lanes, irq gating and mid-run reset.
module tb_wb_timer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  wb_timer #(.PRESCALE_WIDTH(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cycle = 0;
  always @(posedge clk_i) cycle <= cycle + 1;

  int   rise_cycle = -1;
  logic irq_prev = 1'b0;
  always @(negedge clk_i) begin
    if (irq_o && !irq_prev) rise_cycle = cycle;
    irq_prev = irq_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int last_commit = 0;
  logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0,
                               32'h0, 32'h0, 32'h0, 32'h0};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (call at posedge + 1) ----------------
  task automatic wb_access(input logic we, input logic [2:0] idx,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {27'd0, idx, 2'b00};
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(posedge clk_i); #1;
    last_commit = cycle;
    check_eq("ack_rise", {31'd0, wb_ack_o}, 32'd1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic [31:0] unused_r;
    wb_access(1'b1, idx, dat, sel, unused_r);
  endtask

  task automatic wb_read_chk(input logic [2:0] idx, input logic [31:0] exp,
                             input string tag);
    logic [31:0] r;
    wb_access(1'b0, idx, 32'd0, 4'h0, r);
    check_eq(tag, r, exp);
  endtask

  task automatic wait_to(input int n);
    while (cycle < n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic check_reset_regs(input string pfx);
    for (int i = 0; i < 8; i++) begin
      wb_read_chk(3'(i), rst_exp[i], $sformatf("%s_reg%0d", pfx, i));
    end
    check_eq({pfx, "_irq"}, {31'd0, irq_o}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int k;

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset values.
    check_eq("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check_reset_regs("rst");

    // stb held high: ack, forced low, ack again.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    @(posedge clk_i); #1;
    check_eq("ack_hold_1", {31'd0, wb_ack_o}, 32'd1);
    @(posedge clk_i); #1;
    check_eq("ack_forced_low", {31'd0, wb_ack_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("ack_hold_2", {31'd0, wb_ack_o}, 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk_i); #1;

    // Auto-reload, PRESCALE=0, COMPARE=4: match every 5 cycles.
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd2, 32'd4, 4'hF);
    rise_cycle = -1;
    wb_write(3'd0, 32'h7, 4'hF);
    k = last_commit;
    wb_read_chk(3'd3, 32'd1, "ar_cnt_k1");
    wb_read_chk(3'd3, 32'd3, "ar_cnt_k3");
    wb_read_chk(3'd3, 32'd0, "ar_cnt_k5");
    wb_read_chk(3'd3, 32'd2, "ar_cnt_k7");
    check_eq("ar_irq_rise", 32'(rise_cycle), 32'(k + 5));
    wait_to(k + 10);
    wb_write(3'd4, 32'd1, 4'h1);
    check_eq("ar_irq_clr", {31'd0, irq_o}, 32'd0);
    rise_cycle = -1;
    wait_to(k + 16);
    check_eq("ar_irq_rearm", 32'(rise_cycle), 32'(k + 15));

    // Clear PEND on a match edge: set wins.
    wait_to(k + 19);
    wb_write(3'd4, 32'd1, 4'h1);
    check_eq("col_pend_irq", {31'd0, irq_o}, 32'd1);
    wb_read_chk(3'd4, 32'd1, "col_pend_sts");

    // One-shot, PRESCALE=3, COMPARE=2: ticks at k+4, k+8, stop at k+12.
    wb_write(3'd0, 32'h0, 4'hF);
    wb_write(3'd4, 32'd1, 4'h1);
    wb_write(3'd3, 32'd0, 4'hF);
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd2, 32'd2, 4'hF);
    wb_write(3'd0, 32'h5, 4'hF);
    k = last_commit;
    wb_read_chk(3'd3, 32'd0, "os_cnt_k1");
    wb_read_chk(3'd3, 32'd0, "os_cnt_k3");
    wb_read_chk(3'd3, 32'd1, "os_cnt_k5");
    wb_read_chk(3'd3, 32'd1, "os_cnt_k7");
    wb_read_chk(3'd3, 32'd2, "os_cnt_k9");
    wb_read_chk(3'd3, 32'd2, "os_cnt_k11");
    wb_read_chk(3'd0, 32'h4, "os_ctrl_en_clr");
    wb_read_chk(3'd4, 32'd1, "os_pend");
    wb_read_chk(3'd3, 32'd2, "os_cnt_hold");
    check_eq("os_irq", {31'd0, irq_o}, 32'd1);

    // COUNT write on a tick edge wins.
    wb_write(3'd3, 32'd0, 4'hF);
    wb_write(3'd4, 32'd1, 4'h1);
    wb_write(3'd2, 32'h100, 4'hF);
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd0, 32'h1, 4'hF);
    k = last_commit;
    wait_to(k + 7);
    wb_write(3'd3, 32'h10, 4'hF);
    wb_read_chk(3'd3, 32'h10, "col_cnt_wr");

    // Wrap 0xFFFFFFFF -> 0 without a match (tick at k+16).
    wait_to(k + 12);
    wb_write(3'd2, 32'd5, 4'hF);
    wb_write(3'd3, 32'hFFFF_FFFF, 4'hF);
    wb_read_chk(3'd3, 32'd0, "wrap_cnt");
    wb_read_chk(3'd4, 32'd0, "wrap_pend");

    // Byte lanes.
    wb_write(3'd0, 32'h0, 4'hF);
    wb_write(3'd2, 32'hFFFF_FFFF, 4'hF);
    wb_write(3'd2, 32'hAABB_CCDD, 4'b0100);
    wb_read_chk(3'd2, 32'hFFBB_FFFF, "lane_cmp");

    // IRQ gating: match with IRQ_EN=0, then enable.
    wb_write(3'd3, 32'd0, 4'hF);
    wb_write(3'd4, 32'd1, 4'h1);
    wb_write(3'd1, 32'd0, 4'hF);
    wb_write(3'd2, 32'd2, 4'hF);
    wb_write(3'd0, 32'h3, 4'hF);
    wb_read_chk(3'd4, 32'd0, "gate_pend_pre");
    wb_read_chk(3'd4, 32'd1, "gate_pend");
    check_eq("gate_irq_off", {31'd0, irq_o}, 32'd0);
    wb_write(3'd0, 32'h7, 4'hF);
    check_eq("gate_irq_on", {31'd0, irq_o}, 32'd1);

    // Reset during a running timer and an in-flight access.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'hC; wb_dat_i = 32'h55; wb_sel_i = 4'hF;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("mrst_no_ack_1", {31'd0, wb_ack_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("mrst_no_ack_2", {31'd0, wb_ack_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_i = 1'b0;
    check_reset_regs("mrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
